// File: rtl/adc_scan_sequencer.sv
// Purpose: SPI mode-0 master that scans the enabled channels of a 10-channel ADC, one 25-clock frame per channel.
// Latency: start sampled at edge N -> CS low / busy at edge N+1; frame 51*CLK_DIV cycles, then GAP_CYC cycles CS high.
// Backpressure: none; results are one-cycle strobes and starts arriving while busy are dropped.
//
// Ports:
//   i_clk, i_rst        system clock, synchronous active-high reset
//   i_start             pulse, begins a scan when idle and the mask is non-zero
//   i_continuous        at end of scan, re-latch i_ch_mask and scan again
//   i_ch_mask[9:0]      channel enables, latched at scan start
//   i_spi_miso          ADC serial data
//   o_spi_sclk/mosi/cs_n  SPI pins (SCLK idles low, CS active low)
//   o_busy              scan in progress
//   o_data/o_ch         last conversion result and its channel
//   o_valid             one-cycle strobe when o_data/o_ch update
//   o_scan_done         one-cycle strobe alongside the final o_valid of a scan
module adc_scan_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_continuous,
    input  logic [9:0]  i_ch_mask,
    input  logic        i_spi_miso,
    output logic        o_spi_sclk,
    output logic        o_spi_mosi,
    output logic        o_spi_cs_n,
    output logic        o_busy,
    output logic [15:0] o_data,
    output logic [3:0]  o_ch,
    output logic        o_valid,
    output logic        o_scan_done
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       pulse;       // SCLK pulse number of the current frame, 1..25
    logic [9:0]       mask_lat;
    logic [3:0]       ch;
    logic [7:0]       cmd_sr;      // command bits still to send; bit 7 goes out on the next falling edge
    logic [15:0]      rx_sr;
    logic             start_pend;  // start accepted, CS drops on the following edge

    logic [3:0]       next_ch;
    logic             has_next;
    logic [3:0]       launch_ch;
    logic [7:0]       launch_cmd;

    function automatic logic [7:0] cmd_byte(input logic [3:0] c);
        logic [7:0] b;
        case (c)
            4'd0:    b = 8'h86;
            4'd1:    b = 8'h8E;
            4'd2:    b = 8'h96;
            4'd3:    b = 8'h9E;
            4'd4:    b = 8'hC6;
            4'd5:    b = 8'hCE;
            4'd6:    b = 8'hD6;
            4'd7:    b = 8'hDE;
            4'd8:    b = 8'hEE;
            4'd9:    b = 8'hF6;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [3:0] lowest_ch(input logic [9:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = 9; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Next-higher enabled channel in the latched mask, relative to the current one.
    always_comb begin
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            if (mask_lat[i] && (4'(i) > ch)) begin
                next_ch  = 4'(i);
                has_next = 1'b1;
            end
        end
    end

    // Channel of the frame about to start: from IDLE it was chosen when the
    // start was accepted; from GAP it is the next channel or, on a rescan,
    // the lowest channel of the freshly sampled mask.
    always_comb begin
        launch_ch = ch;
        if (state == GAP) begin
            launch_ch = has_next ? next_ch : lowest_ch(i_ch_mask);
        end
        launch_cmd = cmd_byte(launch_ch);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pulse       <= '0;
            mask_lat    <= '0;
            ch          <= '0;
            cmd_sr      <= '0;
            rx_sr       <= '0;
            start_pend  <= 1'b0;
            o_spi_sclk  <= 1'b0;
            o_spi_mosi  <= 1'b0;
            o_spi_cs_n  <= 1'b1;
            o_busy      <= 1'b0;
            o_data      <= '0;
            o_ch        <= '0;
            o_valid     <= 1'b0;
            o_scan_done <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pend) begin
                        start_pend <= 1'b0;
                        o_busy     <= 1'b1;
                        ch         <= launch_ch;
                        o_spi_cs_n <= 1'b0;
                        o_spi_sclk <= 1'b0;
                        o_spi_mosi <= launch_cmd[7];
                        cmd_sr     <= {launch_cmd[6:0], 1'b0};
                        cnt        <= '0;
                        state      <= SETUP;
                    end else if (i_start && (i_ch_mask != 10'd0)) begin
                        mask_lat   <= i_ch_mask;
                        ch         <= lowest_ch(i_ch_mask);
                        start_pend <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt        <= '0;
                        o_spi_sclk <= 1'b1;
                        pulse      <= 5'd1;
                        state      <= SCLK_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCLK_HI: begin
                    if (cnt == DIV_LAST) begin
                        cnt        <= '0;
                        o_spi_sclk <= 1'b0;
                        // Shifts out bits 6..0 after pulses 1..7, zeros afterwards.
                        o_spi_mosi <= cmd_sr[7];
                        cmd_sr     <= {cmd_sr[6:0], 1'b0};
                        state      <= SCLK_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCLK_LO: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (pulse == 5'd25) begin
                            o_spi_cs_n  <= 1'b1;
                            o_data      <= rx_sr;
                            o_ch        <= ch;
                            o_valid     <= 1'b1;
                            o_scan_done <= ~has_next;
                            state       <= GAP;
                        end else begin
                            o_spi_sclk <= 1'b1;
                            pulse      <= pulse + 5'd1;
                            // Rising edges 10..25 carry result bits; 9 is turnaround.
                            if (pulse >= 5'd9) begin
                                rx_sr <= {rx_sr[14:0], i_spi_miso};
                            end
                            state <= SCLK_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (has_next || (i_continuous && (i_ch_mask != 10'd0))) begin
                            if (!has_next) begin
                                mask_lat <= i_ch_mask;
                            end
                            ch         <= launch_ch;
                            o_spi_cs_n <= 1'b0;
                            o_spi_sclk <= 1'b0;
                            o_spi_mosi <= launch_cmd[7];
                            cmd_sr     <= {launch_cmd[6:0], 1'b0};
                            state      <= SETUP;
                        end else begin
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Purpose: self-checking bench for adc_scan_sequencer with an ADC slave model and a frame/strobe scoreboard.
// Latency: checks start latency, CS low time, inter-frame gap and strobe alignment against channel-list expectations.
// Backpressure: not applicable; the slave answers every frame.
module tb_adc_scan_sequencer;

    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 8;
    localparam int CS_LOW  = 51 * CLK_DIV;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        i_continuous;
    logic [9:0]  i_ch_mask;
    logic        i_spi_miso;
    logic        o_spi_sclk;
    logic        o_spi_mosi;
    logic        o_spi_cs_n;
    logic        o_busy;
    logic [15:0] o_data;
    logic [3:0]  o_ch;
    logic        o_valid;
    logic        o_scan_done;

    adc_scan_sequencer #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_continuous (i_continuous),
        .i_ch_mask    (i_ch_mask),
        .i_spi_miso   (i_spi_miso),
        .o_spi_sclk   (o_spi_sclk),
        .o_spi_mosi   (o_spi_mosi),
        .o_spi_cs_n   (o_spi_cs_n),
        .o_busy       (o_busy),
        .o_data       (o_data),
        .o_ch         (o_ch),
        .o_valid      (o_valid),
        .o_scan_done  (o_scan_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  cmd;
        int          low;
        int          rises;
        logic        tail;
        logic [15:0] word;
        int          gap;
    } frame_t;

    typedef struct {
        int          ch;
        logic [15:0] data;
        logic        done;
    } valid_t;

    logic [7:0] cmd_tab [10] = '{8'h86, 8'h8E, 8'h96, 8'h9E, 8'hC6,
                                 8'hCE, 8'hD6, 8'hDE, 8'hEE, 8'hF6};

    int checks = 0;
    int passed = 0;
    int failed = 0;

    frame_t frames_q[$];
    valid_t valid_q[$];
    int     exp_ch[$];
    logic   exp_done[$];

    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    int          hi_cnt = 0;
    int          cur_low = 0;
    int          cur_rises = 0;
    int          cur_gap = 0;
    logic [7:0]  cur_cmd = '0;
    logic        cur_tail = 1'b0;
    int          fall_cnt = 0;
    logic [15:0] slave_word = '0;
    logic        fixed_en = 1'b0;
    logic [15:0] fixed_word = '0;
    int          misaligned = 0;
    int          stray_done = 0;
    int          busy_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC slave plus pin/strobe monitor, evaluated once per cycle away from the clock edge.
    task automatic monitor();
        frame_t f;
        valid_t v;
        if (!o_spi_cs_n) begin
            if (prev_cs) begin
                cur_gap    = hi_cnt;
                cur_low    = 0;
                cur_rises  = 0;
                cur_cmd    = '0;
                cur_tail   = 1'b0;
                fall_cnt   = 0;
                slave_word = fixed_en ? fixed_word : 16'($urandom);
                i_spi_miso = 1'($urandom);
            end
            cur_low = cur_low + 1;
            hi_cnt  = 0;
            if (o_spi_sclk && !prev_sclk) begin
                cur_rises = cur_rises + 1;
                if (cur_rises <= 8) cur_cmd = {cur_cmd[6:0], o_spi_mosi};
                else cur_tail = cur_tail | o_spi_mosi;
            end
            if (!o_spi_sclk && prev_sclk) begin
                fall_cnt = fall_cnt + 1;
                if (fall_cnt >= 9 && fall_cnt <= 24) i_spi_miso = slave_word[24 - fall_cnt];
                else i_spi_miso = 1'($urandom);
            end
        end else begin
            if (!prev_cs) begin
                f.cmd = cur_cmd; f.low = cur_low; f.rises = cur_rises;
                f.tail = cur_tail; f.word = slave_word; f.gap = cur_gap;
                frames_q.push_back(f);
            end
            hi_cnt = hi_cnt + 1;
        end
        if (o_valid) begin
            v.ch = int'(o_ch); v.data = o_data; v.done = o_scan_done;
            valid_q.push_back(v);
            if (!(o_spi_cs_n && !prev_cs)) misaligned = misaligned + 1;
        end else if (o_scan_done) begin
            stray_done = stray_done + 1;
        end
        if (o_busy) busy_seen = busy_seen + 1;
        prev_cs   = o_spi_cs_n;
        prev_sclk = o_spi_sclk;
    endtask

    task automatic step();
        @(negedge i_clk);
        monitor();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [9:0] m);
        i_ch_mask = m;
        i_start   = 1'b1;
        step();
        i_start   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (o_busy && n < max) begin
            step();
            n = n + 1;
        end
        chk(tag, {31'd0, o_busy}, 32'd0);
        step();
    endtask

    task automatic wait_valids(input string tag, input int k, input int max);
        int n = 0;
        while (valid_q.size() < k && n < max) begin
            step();
            n = n + 1;
        end
        chk(tag, valid_q.size() >= k, 32'd1);
    endtask

    // Reference: a scan visits the set bits of its mask in ascending order;
    // only the last visit carries scan_done.
    task automatic model_scan(input logic [9:0] m);
        for (int c = 0; c < 10; c++) begin
            if (m[c]) begin
                exp_ch.push_back(c);
                exp_done.push_back(1'b0);
            end
        end
        exp_done[exp_done.size() - 1] = 1'b1;
    endtask

    task automatic clear_all();
        frames_q.delete();
        valid_q.delete();
        exp_ch.delete();
        exp_done.delete();
    endtask

    task automatic check_results(input string tag);
        chk($sformatf("%s_nframes", tag), frames_q.size(), exp_ch.size());
        chk($sformatf("%s_nvalid", tag), valid_q.size(), exp_ch.size());
        for (int i = 0; i < exp_ch.size() && i < frames_q.size() && i < valid_q.size(); i++) begin
            chk($sformatf("%s_cmd%0d", tag, i), frames_q[i].cmd, cmd_tab[exp_ch[i]]);
            chk($sformatf("%s_cslow%0d", tag, i), frames_q[i].low, CS_LOW);
            chk($sformatf("%s_pulses%0d", tag, i), frames_q[i].rises, 25);
            chk($sformatf("%s_mosi_tail%0d", tag, i), frames_q[i].tail, 0);
            if (i > 0) chk($sformatf("%s_gap%0d", tag, i), frames_q[i].gap, GAP_CYC);
            chk($sformatf("%s_ch%0d", tag, i), valid_q[i].ch, exp_ch[i]);
            chk($sformatf("%s_data%0d", tag, i), valid_q[i].data, frames_q[i].word);
            chk($sformatf("%s_done%0d", tag, i), valid_q[i].done, exp_done[i]);
        end
        clear_all();
    endtask

    initial begin
        logic [9:0] m;
        int n;
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_continuous = 1'b0;
        i_ch_mask    = '0;
        i_spi_miso   = 1'b0;
        repeat (3) step();
        chk("rst_cs_n", o_spi_cs_n, 1);
        chk("rst_sclk", o_spi_sclk, 0);
        chk("rst_mosi", o_spi_mosi, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", o_data, 0);
        chk("rst_ch", o_ch, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_done", o_scan_done, 0);
        i_rst = 1'b0;
        step();

        // Single channel 0 with a known result word.
        fixed_en = 1'b1;
        fixed_word = 16'h0BC0;
        pulse_start(10'h001);
        chk("lat_cs_edge_n", o_spi_cs_n, 1);
        step();
        chk("lat_cs_edge_n1", o_spi_cs_n, 0);
        chk("lat_busy_edge_n1", o_busy, 1);
        model_scan(10'h001);
        wait_idle("s1_idle", 2000);
        chk("s1_data", o_data, 16'h0BC0);
        chk("s1_ch", o_ch, 0);
        check_results("s1");
        fixed_en = 1'b0;

        // Channels 0 and 9.
        pulse_start(10'h201);
        step();
        model_scan(10'h201);
        wait_idle("s2_idle", 2000);
        check_results("s2");

        // Empty mask start is ignored, then channel 4.
        busy_seen = 0;
        pulse_start(10'h000);
        repeat (20) step();
        chk("s3_busy_seen", busy_seen, 0);
        chk("s3_no_frames", frames_q.size(), 0);
        chk("s3_no_valid", valid_q.size(), 0);
        pulse_start(10'h010);
        step();
        model_scan(10'h010);
        wait_idle("s3b_idle", 2000);
        check_results("s3b");

        // Continuous 0,1 scans, stopped during channel 1 of the second scan.
        i_continuous = 1'b1;
        pulse_start(10'h003);
        step();
        wait_valids("s4_wait3", 3, 3000);
        n = 0;
        while (o_spi_cs_n && n < 100) begin
            step();
            n = n + 1;
        end
        repeat (10) step();
        i_continuous = 1'b0;
        model_scan(10'h003);
        model_scan(10'h003);
        wait_idle("s4_idle", 2000);
        check_results("s4");

        // Reset in the middle of the channel 3 frame.
        pulse_start(10'h3FF);
        step();
        n = 0;
        while (!(frames_q.size() == 3 && !o_spi_cs_n && cur_rises == 12) && n < 3000) begin
            step();
            n = n + 1;
        end
        chk("s5_reached_pulse12", cur_rises, 12);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("s5_cs_n", o_spi_cs_n, 1);
        chk("s5_sclk", o_spi_sclk, 0);
        chk("s5_mosi", o_spi_mosi, 0);
        chk("s5_busy", o_busy, 0);
        chk("s5_data", o_data, 0);
        chk("s5_ch", o_ch, 0);
        chk("s5_valid", o_valid, 0);
        chk("s5_done", o_scan_done, 0);
        repeat (20) step();
        chk("s5_nvalid", valid_q.size(), 3);
        clear_all();
        pulse_start(10'h3FF);
        step();
        model_scan(10'h3FF);
        wait_idle("s5b_idle", 3000);
        check_results("s5b");

        // Extra starts mid-frame and during the final gap are ignored.
        pulse_start(10'h004);
        step();
        repeat (30) step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_valids("s6_wait1", 1, 1000);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_idle("s6_idle", 1000);
        repeat (40) step();
        model_scan(10'h004);
        check_results("s6");

        // Random masks with the mask input disturbed mid-scan.
        for (int r = 0; r < 3; r++) begin
            m = 10'($urandom_range(1, 1023));
            pulse_start(m);
            step();
            repeat (50) step();
            i_ch_mask = 10'($urandom);
            model_scan(m);
            wait_idle($sformatf("rnd%0d_idle", r), 3000);
            check_results($sformatf("rnd%0d", r));
        end

        chk("valid_cs_alignment", misaligned, 0);
        chk("done_without_valid", stray_done, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
